// File: rtl/fb_write_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fb_write_scheduler
// Purpose  : Turns single-pixel write requests and whole-screen clear requests
//            into per-partition, per-lane framebuffer write strobes. The
//            framebuffer is split into PARTITION banks, each holding
//            WORDS_PER_PART words of PIXELS_PER_DATA pixels. Consecutive
//            words are interleaved across the partitions.
// Ports    : clk          - sole clock, rising edge
//            reset        - synchronous active-high reset
//            px_valid     - pixel write request
//            px_ready     - pixel request accepted when px_valid & px_ready
//            px_x, px_y   - pixel coordinate
//            px_color     - pixel value
//            clear_start  - one-cycle request to fill the whole framebuffer
//            clear_color  - fill value, sampled with clear_start
//            clear_busy   - high while clear writes are being issued
//            clear_done   - pulse concurrent with the last clear write
//            err_oob      - sticky flag, out-of-range pixel seen
//            fb_wr_addr   - per-partition word address
//            fb_wr_data   - per-lane write data
//            fb_wr_en     - per-lane write enable
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fb_write_scheduler #(
   parameter int  RESOLUTION_X    = 400,
   parameter int  RESOLUTION_Y    = 300,
   parameter int  PIXEL_BITS      = 8,
   localparam int PIXEL_COUNT     = RESOLUTION_X * RESOLUTION_Y,
   localparam int PARTITION       = 16,
   localparam int PIXELS_PER_DATA = 4,
   localparam int WORDS_PER_PART  = PIXEL_COUNT / 64,
   localparam int ADDR_BITS       = (WORDS_PER_PART > 1) ? $clog2(WORDS_PER_PART) : 1,
   localparam int X_BITS          = $clog2(RESOLUTION_X),
   localparam int Y_BITS          = $clog2(RESOLUTION_Y)
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic                                                   px_valid,
   output logic                                                   px_ready,
   input  logic [X_BITS-1:0]                                      px_x,
   input  logic [Y_BITS-1:0]                                      px_y,
   input  logic [PIXEL_BITS-1:0]                                  px_color,
   input  logic                                                   clear_start,
   input  logic [PIXEL_BITS-1:0]                                  clear_color,
   output logic                                                   clear_busy,
   output logic                                                   clear_done,
   output logic                                                   err_oob,
   output logic [PARTITION-1:0][ADDR_BITS-1:0]                    fb_wr_addr,
   output logic [PARTITION-1:0][PIXELS_PER_DATA-1:0][PIXEL_BITS-1:0] fb_wr_data,
   output logic [PARTITION-1:0][PIXELS_PER_DATA-1:0]              fb_wr_en
);

   // Linear pixel index width; wide enough for every in-range pixel.
   localparam int IDX_BITS = $clog2(PIXEL_COUNT);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   // One extra bit so that a power-of-two resolution does not wrap to 0.
   localparam logic [X_BITS:0]         c_RES_X_EXT = (X_BITS + 1)'(RESOLUTION_X);
   localparam logic [Y_BITS:0]         c_RES_Y_EXT = (Y_BITS + 1)'(RESOLUTION_Y);
   localparam logic [IDX_BITS-1:0]     c_RES_X_IDX = IDX_BITS'(RESOLUTION_X);
   localparam logic [ADDR_BITS-1:0]    c_LAST_ADDR = ADDR_BITS'(WORDS_PER_PART - 1);

   //---------------------------------------------------------------------------
   // State and output registers
   //---------------------------------------------------------------------------
   logic [0:0]                                              r_state;
   logic [ADDR_BITS-1:0]                                    r_clr_cnt;
   logic [PIXEL_BITS-1:0]                                   r_clr_color;
   logic                                                    r_clear_busy;
   logic                                                    r_clear_done;
   logic                                                    r_err_oob;
   logic [PARTITION-1:0][ADDR_BITS-1:0]                     r_wr_addr;
   logic [PARTITION-1:0][PIXELS_PER_DATA-1:0][PIXEL_BITS-1:0] r_wr_data;
   logic [PARTITION-1:0][PIXELS_PER_DATA-1:0]               r_wr_en;

   //---------------------------------------------------------------------------
   // Pixel address decode
   //---------------------------------------------------------------------------
   logic                  w_x_ok;
   logic                  w_y_ok;
   logic                  w_in_range;
   logic [IDX_BITS-1:0]   w_idx;
   logic [3:0]            w_part;
   logic [1:0]            w_lane;
   logic [ADDR_BITS-1:0]  w_px_addr;
   logic                  w_px_ready;
   logic                  w_accept;

   always_comb begin
      w_x_ok     = {1'b0, px_x} < c_RES_X_EXT;
      w_y_ok     = {1'b0, px_y} < c_RES_Y_EXT;
      w_in_range = w_x_ok & w_y_ok;
      // Out-of-range coordinates may overflow this product; such pixels are
      // dropped, so the wrapped index is never used for a write.
      w_idx      = IDX_BITS'(px_y) * c_RES_X_IDX + IDX_BITS'(px_x);
      w_lane     = w_idx[1:0];
      w_part     = w_idx[5:2];
      w_px_addr  = ADDR_BITS'(w_idx >> 6);
   end

   // clear_start wins over a simultaneous pixel; nothing is accepted in reset.
   assign w_px_ready = ~reset & (r_state == S_IDLE) & ~clear_start;
   assign w_accept   = px_valid & w_px_ready;

   //---------------------------------------------------------------------------
   // Next-state / next-output logic
   //---------------------------------------------------------------------------
   logic [0:0]                                              w_state_nxt;
   logic [ADDR_BITS-1:0]                                    w_cnt_nxt;
   logic [ADDR_BITS-1:0]                                    w_cnt_inc;
   logic                                                    w_last;
   logic                                                    w_busy_nxt;
   logic                                                    w_done_nxt;
   logic                                                    w_fill;
   logic [ADDR_BITS-1:0]                                    w_fill_addr;
   logic [PIXEL_BITS-1:0]                                   w_fill_color;
   logic [PARTITION-1:0][ADDR_BITS-1:0]                     w_addr_nxt;
   logic [PARTITION-1:0][PIXELS_PER_DATA-1:0][PIXEL_BITS-1:0] w_data_nxt;
   logic [PARTITION-1:0][PIXELS_PER_DATA-1:0]               w_en_nxt;

   assign w_cnt_inc = r_clr_cnt + ADDR_BITS'(1);
   assign w_last    = (r_clr_cnt == c_LAST_ADDR);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_clr_cnt;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_fill       = 1'b0;
      w_fill_addr  = '0;
      w_fill_color = r_clr_color;
      w_addr_nxt   = '0;
      w_data_nxt   = '0;
      w_en_nxt     = '0;

      if (r_state == S_IDLE) begin
         if (clear_start) begin
            // First clear write goes out in the very next cycle, so the
            // incoming colour is used directly rather than the latched copy.
            w_state_nxt  = S_CLEAR;
            w_cnt_nxt    = '0;
            w_busy_nxt   = 1'b1;
            w_done_nxt   = (c_LAST_ADDR == '0);
            w_fill       = 1'b1;
            w_fill_addr  = '0;
            w_fill_color = clear_color;
         end else if (w_accept && w_in_range) begin
            w_en_nxt[w_part][w_lane]   = 1'b1;
            w_data_nxt[w_part][w_lane] = px_color;
            w_addr_nxt[w_part]         = w_px_addr;
         end
      end else begin
         // r_clr_cnt holds the address currently on the bus.
         if (w_last) begin
            w_state_nxt = S_IDLE;
         end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = (w_cnt_inc == c_LAST_ADDR);
            w_fill      = 1'b1;
            w_fill_addr = w_cnt_inc;
         end
      end

      if (w_fill) begin
         w_en_nxt = '1;
         for (int p = 0; p < PARTITION; p++) begin
            w_addr_nxt[p] = w_fill_addr;
            for (int l = 0; l < PIXELS_PER_DATA; l++) begin
               w_data_nxt[p][l] = w_fill_color;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_clr_cnt    <= '0;
         r_clr_color  <= '0;
         r_clear_busy <= 1'b0;
         r_clear_done <= 1'b0;
         r_err_oob    <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_en      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_cnt    <= w_cnt_nxt;
         r_clear_busy <= w_busy_nxt;
         r_clear_done <= w_done_nxt;
         r_wr_addr    <= w_addr_nxt;
         r_wr_data    <= w_data_nxt;
         r_wr_en      <= w_en_nxt;
         if (r_state == S_IDLE && clear_start) begin
            r_clr_color <= clear_color;
         end
         if (w_accept && !w_in_range) begin
            r_err_oob <= 1'b1;
         end
      end
   end

   assign px_ready   = w_px_ready;
   assign clear_busy = r_clear_busy;
   assign clear_done = r_clear_done;
   assign err_oob    = r_err_oob;
   assign fb_wr_addr = r_wr_addr;
   assign fb_wr_data = r_wr_data;
   assign fb_wr_en   = r_wr_en;

endmodule
`default_nettype wire
